// File: rtl/sfu_drain_if.sv
// Output word stream from sfu_drain to the output SRAM write port.
// The master holds a word until the slave accepts it with out_ready.
interface sfu_drain_if #(
  parameter int psum_bw = 16,
  parameter int addr_bw = 8
);
  logic               out_valid;
  logic               out_ready;
  logic [psum_bw-1:0] out_data;
  logic [addr_bw-1:0] out_addr;
  logic               out_last;

  modport master (
    output out_valid, out_data, out_addr, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_addr, out_last,
    output out_ready
  );
endinterface

// File: rtl/sfu_drain.sv
// Purpose: capture the parallel sfu psum bundle and stream it one channel per transfer to the output SRAM.
// Latency: load at edge k -> channel 0 valid after edge k; one word per cycle, done one cycle after the last word.
// Backpressure: out_valid is never retracted; without out_ready every output holds until the word is taken.
module sfu_drain #(
  parameter int psum_bw  = 16,
  parameter int input_ch = 16,
  parameter int addr_bw  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [psum_bw*input_ch-1:0] psums_in,
  input  logic                        load,
  input  logic [addr_bw-1:0]          base_addr,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun,
  sfu_drain_if.master                 out_if
);

  localparam int IDX_W = (input_ch > 1) ? $clog2(input_ch) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(input_ch - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [IDX_W-1:0]   idx_q;
  logic [addr_bw-1:0] base_q;
  logic [psum_bw-1:0] shadow_q [input_ch];
  logic               overrun_q;

  logic capture;
  logic xfer;
  logic is_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    capture   = 1'b0;
    xfer      = 1'b0;
    is_last   = (idx_q == LAST_IDX);
    busy      = 1'b0;
    done      = 1'b0;
    out_if.out_valid = 1'b0;
    out_if.out_data  = '0;
    out_if.out_addr  = '0;
    out_if.out_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          capture   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy             = 1'b1;
        out_if.out_valid = 1'b1;
        out_if.out_data  = shadow_q[idx_q];
        out_if.out_addr  = base_q + addr_bw'(idx_q);
        out_if.out_last  = is_last;
        xfer             = out_if.out_ready;
        if (xfer && is_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q     <= '0;
      base_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (capture) begin
        idx_q  <= '0;
        base_q <= base_addr;
      end else if (xfer) begin
        idx_q <= is_last ? '0 : idx_q + 1'b1;
      end
      // Any load outside IDLE is dropped; remember that it happened.
      if (load && state_q != IDLE) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Shadow needs no reset: it is only read after a capture has filled it.
  always_ff @(posedge clk) begin
    if (capture && !reset) begin
      for (int i = 0; i < input_ch; i++) begin
        shadow_q[i] <= psums_in[psum_bw*i +: psum_bw];
      end
    end
  end

  assign overrun = overrun_q;

endmodule
